// File: rtl/neo_sndcmd.sv
// neo_sndcmd: 68k<->Z80 sound command mailbox with strobe synchronisers and NMI generation.
// Define SNDCMD_FIFO_EN to replace the single command latch with a FIFO_DEPTH-entry queue.
module neo_sndcmd #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       CLK_24M,
   input  logic       nRESET,
   input  logic [7:0] M68K_DATA_HI,
   input  logic       nSDW,
   input  logic       nSDR68,
   input  logic [7:0] SDD_IN,
   input  logic       nSDZ80R,
   input  logic       nSDZ80W,
   input  logic       nSDZ80CLR,
   input  logic       nNMIEN_W,
   input  logic       nNMIDIS_W,
   output logic [7:0] SDD_OUT,
   output logic       SDD_OE,
   output logic [7:0] M68K_REPLY,
   output logic       nZ80NMI,
   output logic       CMD_PENDING,
   output logic       REPLY_VALID,
   output logic       OVERRUN
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("neo_sndcmd: SYNC_STAGES must be 2 or 3");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("neo_sndcmd: FIFO_DEPTH must be a power of two in 2..8");
   end

   localparam int NS = 6;
   // nSDR68 is the only strobe that acts on its deassertion edge
   localparam logic [NS-1:0] RISE_MASK = 6'b000010;

   logic [NS-1:0] strb_raw, strb_s, arm_q, ev;
   logic [NS-1:0] strb_q [SYNC_STAGES];
   logic [7:0]    dhi_q  [SYNC_STAGES];
   logic [7:0]    dz_q   [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] fill_q;
   logic          wr_ev, rd_ev, rpl_ev, clr_ev, en_ev, dis_ev;
   logic [7:0]    dhi_s, dz_s;

   assign strb_raw = {nNMIDIS_W, nNMIEN_W, nSDZ80CLR, nSDZ80W, nSDR68, nSDW};
   assign strb_s   = strb_q[SYNC_STAGES-1];
   assign dhi_s    = dhi_q[SYNC_STAGES-1];
   assign dz_s     = dz_q[SYNC_STAGES-1];

   // arm_q only fills once the chain holds real pin samples, so a strobe held
   // through reset release must be seen idle before it can produce an event.
   always_ff @(posedge CLK_24M) begin
      if (!nRESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) strb_q[i] <= '1;
         fill_q <= '0;
         arm_q  <= '0;
      end else begin
         strb_q[0] <= strb_raw;
         for (int i = 1; i < SYNC_STAGES; i++) strb_q[i] <= strb_q[i-1];
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         arm_q  <= fill_q[SYNC_STAGES-1] ? (strb_s ^ RISE_MASK) : '0;
      end
   end

   always_ff @(posedge CLK_24M) begin
      dhi_q[0] <= M68K_DATA_HI;
      dz_q[0]  <= SDD_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         dhi_q[i] <= dhi_q[i-1];
         dz_q[i]  <= dz_q[i-1];
      end
   end

   assign ev     = arm_q & ~(strb_s ^ RISE_MASK);
   assign wr_ev  = ev[0];
   assign rd_ev  = ev[1];
   assign rpl_ev = ev[2];
   assign clr_ev = ev[3];
   assign en_ev  = ev[4];
   assign dis_ev = ev[5];

   logic [7:0] rep_q, rep_d;
   logic       rv_q, rv_d, en_q, en_d, ovr_q, ovr_d, nmi_n_q, pend;

`ifdef SNDCMD_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [7:0]  fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rdp_q, rdp_d, wrp_q, wrp_d;
   logic [PW:0] cnt_q, cnt_d;
   logic        full, empty, push, pop;

   assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign pop   = clr_ev & ~empty;
   assign push  = wr_ev & (~full | pop);
   assign pend  = ~empty;
   assign SDD_OUT = empty ? 8'h00 : fifo_q[rdp_q];

   always_ff @(posedge CLK_24M) begin
      if (push) fifo_q[wrp_q] <= dhi_s;
   end
`else
   logic [7:0] cmd_q, cmd_d;
   logic       pend_q, pend_d;

   assign pend    = pend_q;
   assign SDD_OUT = cmd_q;
`endif

   always_comb begin
      rep_d = rep_q;
      rv_d  = rv_q;
      en_d  = en_q;
      ovr_d = ovr_q;
      if (rpl_ev)      begin rep_d = dz_s; rv_d = 1'b1; end
      else if (rd_ev)  rv_d = 1'b0;
      if (dis_ev)      en_d = 1'b0;
      else if (en_ev)  en_d = 1'b1;
`ifdef SNDCMD_FIFO_EN
      rdp_d = rdp_q + PW'(pop);
      wrp_d = wrp_q + PW'(push);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (wr_ev && !push) ovr_d = 1'b1;
`else
      cmd_d  = cmd_q;
      pend_d = pend_q;
      if (wr_ev) begin
         cmd_d  = dhi_s;
         pend_d = 1'b1;
         if (pend_q) ovr_d = 1'b1;
      end else if (clr_ev) begin
         pend_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge CLK_24M) begin
      if (!nRESET) begin
         rep_q   <= 8'h00;
         rv_q    <= 1'b0;
         en_q    <= 1'b0;
         ovr_q   <= 1'b0;
         nmi_n_q <= 1'b1;
`ifdef SNDCMD_FIFO_EN
         rdp_q   <= '0;
         wrp_q   <= '0;
         cnt_q   <= '0;
`else
         cmd_q   <= 8'h00;
         pend_q  <= 1'b0;
`endif
      end else begin
         rep_q   <= rep_d;
         rv_q    <= rv_d;
         en_q    <= en_d;
         ovr_q   <= ovr_d;
         nmi_n_q <= ~(en_q & pend);
`ifdef SNDCMD_FIFO_EN
         rdp_q   <= rdp_d;
         wrp_q   <= wrp_d;
         cnt_q   <= cnt_d;
`else
         cmd_q   <= cmd_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign SDD_OE      = ~nSDZ80R & nRESET;
   assign M68K_REPLY  = rep_q;
   assign nZ80NMI     = nmi_n_q;
   assign CMD_PENDING = pend;
   assign REPLY_VALID = rv_q;
   assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_neo_sndcmd.sv
// tb_neo_sndcmd: directed and randomized mailbox transactions checked against a transaction-level model.
module tb_neo_sndcmd;
   localparam int S     = 2;
   localparam int DEPTH = 4;

   logic       CLK_24M = 1'b0;
   logic       nRESET = 1'b0;
   logic [7:0] M68K_DATA_HI = 8'h00;
   logic [7:0] SDD_IN = 8'h00;
   logic       nSDW = 1'b1, nSDR68 = 1'b1, nSDZ80R = 1'b1, nSDZ80W = 1'b1;
   logic       nSDZ80CLR = 1'b1, nNMIEN_W = 1'b1, nNMIDIS_W = 1'b1;
   logic [7:0] SDD_OUT, M68K_REPLY;
   logic       SDD_OE, nZ80NMI, CMD_PENDING, REPLY_VALID, OVERRUN;

   always #5 CLK_24M = ~CLK_24M;

   neo_sndcmd #(.SYNC_STAGES(S), .FIFO_DEPTH(DEPTH)) dut (
      .CLK_24M(CLK_24M), .nRESET(nRESET), .M68K_DATA_HI(M68K_DATA_HI),
      .nSDW(nSDW), .nSDR68(nSDR68), .SDD_IN(SDD_IN), .nSDZ80R(nSDZ80R),
      .nSDZ80W(nSDZ80W), .nSDZ80CLR(nSDZ80CLR), .nNMIEN_W(nNMIEN_W),
      .nNMIDIS_W(nNMIDIS_W), .SDD_OUT(SDD_OUT), .SDD_OE(SDD_OE),
      .M68K_REPLY(M68K_REPLY), .nZ80NMI(nZ80NMI), .CMD_PENDING(CMD_PENDING),
      .REPLY_VALID(REPLY_VALID), .OVERRUN(OVERRUN)
   );

   int vectors = 0;
   int miscompares = 0;

   // Mailbox model: command queue (depth 1 with overwrite when the FIFO is absent)
   logic [7:0] mq[$];
   logic [7:0] m_cmd = 8'h00, m_reply = 8'h00;
   bit         m_pend = 0, m_ovr = 0, m_rv = 0, m_en = 0;

   localparam logic [5:0] B_W = 6'b000001, B_RD = 6'b000010, B_ZW = 6'b000100;
   localparam logic [5:0] B_CLR = 6'b001000, B_EN = 6'b010000, B_DIS = 6'b100000;

   function automatic bit exp_pend();
`ifdef SNDCMD_FIFO_EN
      return mq.size() != 0;
`else
      return m_pend;
`endif
   endfunction

   function automatic logic [7:0] exp_out();
`ifdef SNDCMD_FIFO_EN
      return (mq.size() != 0) ? mq[0] : 8'h00;
`else
      return m_cmd;
`endif
   endfunction

   task automatic m_reset();
      mq.delete();
      m_cmd = 8'h00; m_reply = 8'h00;
      m_pend = 0; m_ovr = 0; m_rv = 0; m_en = 0;
   endtask

   task automatic m_write(input logic [7:0] d, input bit with_clear);
`ifdef SNDCMD_FIFO_EN
      bit had, full;
      had  = mq.size() != 0;
      full = mq.size() == DEPTH;
      if (with_clear && had) void'(mq.pop_front());
      if (!full || (with_clear && had)) mq.push_back(d);
      else m_ovr = 1;
`else
      if (m_pend) m_ovr = 1;
      m_cmd  = d;
      m_pend = 1;
      if (with_clear) m_pend = 1;
`endif
   endtask

   task automatic m_clear();
`ifdef SNDCMD_FIFO_EN
      if (mq.size() != 0) void'(mq.pop_front());
`else
      m_pend = 0;
`endif
   endtask

   task automatic tick();
      @(posedge CLK_24M);
      #1;
   endtask

   task automatic drive(input logic [5:0] lvl);
      {nNMIDIS_W, nNMIEN_W, nSDZ80CLR, nSDZ80W, nSDR68, nSDW} = lvl;
   endtask

   task automatic strobe(input logic [5:0] mask);
      drive(~mask);
      repeat (S + 1) tick();
      drive('1);
      repeat (4) tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sdd_out"}, SDD_OUT, exp_out());
      chk({tag, ".pending"}, {7'b0, CMD_PENDING}, {7'b0, exp_pend()});
      chk({tag, ".overrun"}, {7'b0, OVERRUN}, {7'b0, m_ovr});
      chk({tag, ".reply"}, M68K_REPLY, m_reply);
      chk({tag, ".reply_valid"}, {7'b0, REPLY_VALID}, {7'b0, m_rv});
      chk({tag, ".nmi_n"}, {7'b0, nZ80NMI}, {7'b0, ~(m_en & exp_pend())});
   endtask

   task automatic wr68(input logic [7:0] d);
      M68K_DATA_HI = d;
      tick();
      strobe(B_W);
      m_write(d, 0);
   endtask

   task automatic z80reply(input logic [7:0] d);
      SDD_IN = d;
      tick();
      strobe(B_ZW);
      m_reply = d;
      m_rv = 1;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      nSDZ80R = 1'b0;
      #1 chk("reset.sdd_oe", {7'b0, SDD_OE}, 8'h00);
      nSDZ80R = 1'b1;
      m_reset();
      check_all("reset");
      nRESET = 1'b1;
      repeat (S + 2) tick();

      strobe(B_EN);
      m_en = 1;
      check_all("nmien");

      // 68k write $5A with exact latency checks
      M68K_DATA_HI = 8'h5A;
      tick();
      nSDW = 1'b0;
      tick();
      repeat (S - 1) tick();
      chk("wr_lat.pend_early", {7'b0, CMD_PENDING}, 8'h00);
      tick();
      chk("wr_lat.pend", {7'b0, CMD_PENDING}, 8'h01);
      chk("wr_lat.cmd", SDD_OUT, 8'h5A);
      chk("wr_lat.nmi_early", {7'b0, nZ80NMI}, 8'h01);
      tick();
      chk("wr_lat.nmi", {7'b0, nZ80NMI}, 8'h00);
      nSDW = 1'b1;
      repeat (4) tick();
      m_write(8'h5A, 0);
      check_all("wr5a");
      nSDZ80R = 1'b0;
      #1;
      chk("z80rd.oe", {7'b0, SDD_OE}, 8'h01);
      chk("z80rd.data", SDD_OUT, 8'h5A);
      nSDZ80R = 1'b1;
      tick();

      strobe(B_CLR);
      m_clear();
      check_all("clear");

      z80reply(8'hC3);
      check_all("reply_c3");
      strobe(B_RD);
      m_rv = 0;
      check_all("rd68");

      // Back-to-back writes without a clear, then drain
      wr68(8'h01);
      wr68(8'h02);
      check_all("two_wr");
      strobe(B_CLR);
      m_clear();
      check_all("two_wr.clr1");
      strobe(B_CLR);
      m_clear();
      check_all("two_wr.clr2");

      // Write and clear landing in the same cycle while a command is pending
      wr68(8'h10);
      M68K_DATA_HI = 8'h11;
      tick();
      drive(~(B_W | B_CLR));
      repeat (S + 1) begin
         tick();
         chk("simul.nmi_low", {7'b0, nZ80NMI}, 8'h00);
      end
      drive('1);
      repeat (4) begin
         tick();
         chk("simul.nmi_hold", {7'b0, nZ80NMI}, 8'h00);
      end
      m_write(8'h11, 1);
      check_all("simul");

      // Reply write coinciding with 68k read deassertion
      nSDR68 = 1'b0;
      SDD_IN = 8'h77;
      repeat (S + 2) tick();
      nSDZ80W = 1'b0;
      nSDR68  = 1'b1;
      repeat (S + 1) tick();
      nSDZ80W = 1'b1;
      repeat (4) tick();
      m_reply = 8'h77;
      m_rv = 1;
      check_all("reply_vs_rd");

      // NMI disable, enable latency, and disable winning over enable
      strobe(B_DIS);
      m_en = 0;
      check_all("nmidis");
      nNMIEN_W = 1'b0;
      tick();
      repeat (S) tick();
      chk("en_lat.early", {7'b0, nZ80NMI}, 8'h01);
      tick();
      chk("en_lat.nmi", {7'b0, nZ80NMI}, 8'h00);
      nNMIEN_W = 1'b1;
      repeat (4) tick();
      m_en = 1;
      check_all("nmien2");
      strobe(B_EN | B_DIS);
      m_en = 0;
      check_all("en_dis_same");
      strobe(B_EN);
      m_en = 1;

      // Reset while pending with nSDW held low across release
      M68K_DATA_HI = 8'hAB;
      nSDW = 1'b0;
      repeat (2) tick();
      nRESET = 1'b0;
      repeat (2) tick();
      nSDZ80R = 1'b0;
      #1 chk("rst_mid.oe_in_reset", {7'b0, SDD_OE}, 8'h00);
      nRESET = 1'b1;
      #1 chk("rst_mid.oe_after", {7'b0, SDD_OE}, 8'h01);
      nSDZ80R = 1'b1;
      m_reset();
      repeat (S + 4) tick();
      check_all("rst_hold");
      nSDW = 1'b1;
      repeat (4) tick();
      check_all("rst_release");
      wr68(8'hCD);
      check_all("rst_rearm");

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         int op;
         logic [7:0] d;
         op = $urandom_range(0, 6);
         d  = 8'($urandom);
         case (op)
            0: wr68(d);
            1: begin strobe(B_CLR); m_clear(); end
            2: z80reply(d);
            3: begin strobe(B_RD); m_rv = 0; end
            4: begin strobe(B_EN); m_en = 1; end
            5: begin strobe(B_DIS); m_en = 0; end
            default: begin
               nSDZ80R = 1'b0;
               #1;
               chk("rand.z80rd_oe", {7'b0, SDD_OE}, 8'h01);
               chk("rand.z80rd_data", SDD_OUT, exp_out());
               repeat (S + 1) tick();
               nSDZ80R = 1'b1;
               repeat (2) tick();
            end
         endcase
         check_all($sformatf("rand%0d_op%0d", n, op));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
